// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID decoupling queue.
package if_id_pkg;

  // Entry field widths are the largest PC/instruction widths the queue supports.
  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  // Bubble instruction presented when the queue is empty.
  localparam logic [ENTRY_DATA_W-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_ADDR_W-1:0] pc4;
    logic [ENTRY_DATA_W-1:0] inst;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_ptr.sv
// Wrap-around pointer into a DEPTH-entry buffer; DEPTH need not be a power of two.
module if_id_ptr #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins, then explicit wrap from DEPTH-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: buffers fetched {PC, PC+step, inst} so fetch runs during decode stalls.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_STEP = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_Flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] PC,
  input  logic [DATA_W-1:0] IFInst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] PC_id,
  output logic [ADDR_W-1:0] PC_4_id,
  output logic [DATA_W-1:0] IDInst,
  output logic              IF_Flush_id,
  output logic [CNT_W-1:0]  count
);

  if (DEPTH < 2) begin : g_depth_check
    $error("if_id_queue: DEPTH must be at least 2");
  end
  if (ADDR_W > ENTRY_ADDR_W || DATA_W > ENTRY_DATA_W) begin : g_width_check
    $error("if_id_queue: ADDR_W/DATA_W exceed if_id_entry_t field widths");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_id_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop;
  if_id_entry_t     storage [DEPTH];
  if_id_entry_t     wr_entry, head;

  assign if_ready = (count_q != CNT_W'(DEPTH));
  assign id_valid = (count_q != '0);
  assign push     = if_valid & if_ready & ~IF_Flush;
  assign pop      = id_valid & id_ready & ~IF_Flush;

  if_id_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (IF_Flush),
    .inc  (pop),
    .ptr  (rd_ptr)
  );

  if_id_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (IF_Flush),
    .inc  (push),
    .ptr  (wr_ptr)
  );

  // Build the entry at push time; PC+step wraps modulo 2^ADDR_W.
  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = ENTRY_ADDR_W'(PC);
    wr_entry.pc4  = ENTRY_ADDR_W'(PC + ADDR_W'(PC_STEP));
    wr_entry.inst = ENTRY_DATA_W'(IFInst);
  end

  // Data storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !reset) storage[wr_ptr] <= wr_entry;
  end

  // Occupancy: flush empties, simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (IF_Flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy and flush-marker registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      flush_id_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      flush_id_q <= IF_Flush;
    end
  end

  assign head = storage[rd_ptr];

  // Head fields from registered state; bubble when empty.
  always_comb begin
    PC_id   = '0;
    PC_4_id = '0;
    IDInst  = NOP_INST[DATA_W-1:0];
    if (id_valid) begin
      PC_id   = head.pc[ADDR_W-1:0];
      PC_4_id = head.pc4[ADDR_W-1:0];
      IDInst  = head.inst[DATA_W-1:0];
    end
  end

  assign IF_Flush_id = flush_id_q;
  assign count       = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=4 and DEPTH=3 instances share stimulus; each has a queue model.
module tb_if_id_queue;

  typedef logic [63:0] ent_t;  // {pc, inst}

  logic        clk = 1'b0;
  logic        reset, IF_Flush, if_valid, id_ready;
  logic [31:0] PC, IFInst;

  logic        a_if_ready, a_id_valid, a_flush_id;
  logic [31:0] a_pc_id, a_pc4_id, a_inst;
  logic [2:0]  a_count;
  logic        b_if_ready, b_id_valid, b_flush_id;
  logic [31:0] b_pc_id, b_pc4_id, b_inst;
  logic [1:0]  b_count;

  ent_t qa[$];
  ent_t qb[$];
  bit   fla, flb;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .IF_Flush(IF_Flush), .if_valid(if_valid), .if_ready(a_if_ready),
    .PC(PC), .IFInst(IFInst), .id_valid(a_id_valid), .id_ready(id_ready), .PC_id(a_pc_id),
    .PC_4_id(a_pc4_id), .IDInst(a_inst), .IF_Flush_id(a_flush_id), .count(a_count)
  );

  if_id_queue #(.DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .IF_Flush(IF_Flush), .if_valid(if_valid), .if_ready(b_if_ready),
    .PC(PC), .IFInst(IFInst), .id_valid(b_id_valid), .id_ready(id_ready), .PC_id(b_pc_id),
    .PC_4_id(b_pc4_id), .IDInst(b_inst), .IF_Flush_id(b_flush_id), .count(b_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of accepted entries with the handshake rules applied to its size.
  task automatic model_upd(ref ent_t q[$], output bit fl, input int depth);
    bit rdy, vld;
    rdy = (q.size() != depth);
    vld = (q.size() != 0);
    if (reset) begin
      q.delete();
      fl = 1'b0;
    end else if (IF_Flush) begin
      q.delete();
      fl = 1'b1;
    end else begin
      fl = 1'b0;
      if (vld && id_ready) void'(q.pop_front());
      if (if_valid && rdy) q.push_back({PC, IFInst});
    end
  endtask

  task automatic check_one(input int k);
    ent_t  h;
    int    sz, dep;
    bit    fl;
    string p;
    logic [31:0] epc, epc4, einst;
    h = '0;
    if (k == 0) begin
      sz = qa.size(); dep = 4; fl = fla; p = "a";
      if (sz != 0) h = qa[0];
    end else begin
      sz = qb.size(); dep = 3; fl = flb; p = "b";
      if (sz != 0) h = qb[0];
    end
    epc   = (sz != 0) ? h[63:32] : 32'h0;
    epc4  = (sz != 0) ? h[63:32] + 32'd4 : 32'h0;
    einst = (sz != 0) ? h[31:0] : 32'h0;
    if (k == 0) begin
      chk({p, "_id_valid"}, 64'(a_id_valid), 64'(sz != 0));
      chk({p, "_if_ready"}, 64'(a_if_ready), 64'(sz != dep));
      chk({p, "_count"},    64'(a_count),    64'(sz));
      chk({p, "_pc_id"},    64'(a_pc_id),    64'(epc));
      chk({p, "_pc4_id"},   64'(a_pc4_id),   64'(epc4));
      chk({p, "_inst"},     64'(a_inst),     64'(einst));
      chk({p, "_flush_id"}, 64'(a_flush_id), 64'(fl));
    end else begin
      chk({p, "_id_valid"}, 64'(b_id_valid), 64'(sz != 0));
      chk({p, "_if_ready"}, 64'(b_if_ready), 64'(sz != dep));
      chk({p, "_count"},    64'(b_count),    64'(sz));
      chk({p, "_pc_id"},    64'(b_pc_id),    64'(epc));
      chk({p, "_pc4_id"},   64'(b_pc4_id),   64'(epc4));
      chk({p, "_inst"},     64'(b_inst),     64'(einst));
      chk({p, "_flush_id"}, 64'(b_flush_id), 64'(fl));
    end
  endtask

  // One clock: advance both models on the current inputs, then check both DUTs.
  task automatic step();
    bit f;
    model_upd(qa, f, 4); fla = f;
    model_upd(qb, f, 3); flb = f;
    @(posedge clk);
    #1;
    check_one(0);
    check_one(1);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; IF_Flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    PC = '0; IFInst = '0;
  endtask

  initial begin
    logic [31:0] pc_next;
    bit          acc;

    // 1. Reset, then idle.
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("t1_inst", 64'(a_inst), 64'h0);
    chk("t1_if_ready", 64'(a_if_ready), 64'h1);

    // 2. Single push, visible next cycle, consumed the cycle after.
    if_valid = 1'b1; id_ready = 1'b1; PC = 32'h100; IFInst = 32'h8C01_0004;
    step();
    chk("t2_pc", 64'(a_pc_id), 64'h100);
    chk("t2_pc4", 64'(a_pc4_id), 64'h104);
    chk("t2_inst", 64'(a_inst), 64'h8C01_0004);
    if_valid = 1'b0;
    step();
    chk("t2_count", 64'(a_count), 64'h0);

    // 3. Stall and fill; IF re-presents rejected entries.
    id_ready = 1'b0; pc_next = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1'b1; PC = pc_next; IFInst = $urandom;
      acc = (qa.size() != 4);
      step();
      if (acc) pc_next += 32'd4;
    end
    chk("t3_full_ready", 64'(a_if_ready), 64'h0);
    chk("t3_full_count", 64'(a_count), 64'h4);
    chk("t3_hold_pc", 64'(a_pc_id), 64'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_order", 64'(a_pc_id), 64'(i * 4));
      if_valid = (pc_next <= 32'h10); PC = pc_next; IFInst = $urandom;
      acc = if_valid && (qa.size() != 4);
      step();
      if (acc) pc_next += 32'd4;
    end
    if_valid = 1'b0;
    step();

    // 4. DEPTH=3: hold two entries, then continuous push+pop across pointer wrap.
    reset = 1'b1; step(); reset = 1'b0;
    id_ready = 1'b0; if_valid = 1'b1;
    PC = 32'h200; IFInst = $urandom; step();
    PC = 32'h204; IFInst = $urandom; step();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PC = 32'h208 + 32'(i * 4); IFInst = $urandom;
      step();
      chk("t4_count", 64'(b_count), 64'h2);
      chk("t4_pc", 64'(b_pc_id), 64'(32'h204 + 32'(i * 4)));
    end

    // 5. Flush with a concurrent push; single-cycle marker, then a held flush.
    reset = 1'b1; if_valid = 1'b0; step(); reset = 1'b0;
    id_ready = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PC = 32'h300 + 32'(i * 4); IFInst = $urandom; step();
    end
    chk("t5_pre_count", 64'(a_count), 64'h3);
    IF_Flush = 1'b1; PC = 32'h30C;
    step();
    chk("t5_count", 64'(a_count), 64'h0);
    chk("t5_valid", 64'(a_id_valid), 64'h0);
    chk("t5_inst", 64'(a_inst), 64'h0);
    chk("t5_flush_id", 64'(a_flush_id), 64'h1);
    IF_Flush = 1'b0; if_valid = 1'b0;
    step();
    chk("t5_flush_fall", 64'(a_flush_id), 64'h0);
    IF_Flush = 1'b1; if_valid = 1'b1;
    step();
    step();
    chk("t5_held_flush", 64'(a_flush_id), 64'h1);
    chk("t5_held_count", 64'(a_count), 64'h0);
    IF_Flush = 1'b0;

    // 6. Reset over flush+push; then PC+4 wrap at the top of the address space.
    PC = 32'h400; step(); step();
    reset = 1'b1; IF_Flush = 1'b1; if_valid = 1'b1;
    step();
    chk("t6_count", 64'(a_count), 64'h0);
    chk("t6_flush_id", 64'(a_flush_id), 64'h0);
    reset = 1'b0; IF_Flush = 1'b0;
    PC = 32'hFFFF_FFFC; IFInst = 32'h1234_5678;
    step();
    chk("t6_pc", 64'(a_pc_id), 64'hFFFF_FFFC);
    chk("t6_pc4_wrap", 64'(a_pc4_id), 64'h0);
    if_valid = 1'b0; id_ready = 1'b1;
    step();

    // 7. Randomized traffic against the models.
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      IF_Flush = ($urandom_range(0, 15) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 1) != 0);
      PC       = $urandom;
      IFInst   = $urandom;
      if ($urandom_range(0, 7) == 0) PC = 32'hFFFF_FFFC;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
